// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the six-stage pipeline: merges stall
// requests, sequences exception/ERET redirects, and keeps stall statistics.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter logic [7:0]  STALL_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_exc_cnt
);

    localparam int unsigned STALL_W = 6;
    localparam int unsigned RUN_W   = 8;
    localparam int unsigned PERF_W  = 32;
    localparam int unsigned EXC_W   = 16;

    localparam logic [31:0]      EXC_ERET  = 32'h0000_000e;
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [EXC_W-1:0]  EXC_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        MASK = 1'b1
    } state_t;

    state_t           state;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_nxt;
    logic             stall_any;

    // Redirect and stall decode; a flush suppresses every stall request.
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = '0;
        if (!resetn) begin
            if (state == IDLE && excepttype != '0) begin
                flush  = 1'b1;
                new_pc = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
            end else if (stallreq_mem) begin
                stall = STALL_W'(6'b011111);
            end else if (stallreq_ex) begin
                stall = STALL_W'(6'b001111);
            end else if (stallreq_id) begin
                stall = STALL_W'(6'b000111);
            end else if (stallreq_if) begin
                stall = STALL_W'(6'b000011);
            end
        end
    end

    assign stall_any = |stall;

    // Consecutive-stall run length, saturating, cleared by any free cycle.
    always_comb begin
        run_nxt = '0;
        if (stall_any) begin
            run_nxt = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_W'(1);
        end
    end

    // MASK lasts exactly one cycle so the flushed MEM instruction cannot re-fire.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state          <= IDLE;
            run_cnt        <= '0;
            stall_timeout  <= 1'b0;
            perf_stall_cnt <= '0;
            perf_exc_cnt   <= '0;
        end else begin
            state   <= flush ? MASK : IDLE;
            run_cnt <= run_nxt;
            if (stall_any && run_nxt == STALL_TIMEOUT) begin
                stall_timeout <= 1'b1;
            end
            if (stall_any && perf_stall_cnt != PERF_MAX) begin
                perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
            end
            if (flush && perf_exc_cnt != EXC_MAX) begin
                perf_exc_cnt <= perf_exc_cnt + EXC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// watchdog/reset sequences, and randomized traffic against a reference model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype, cp0_epc;
    logic [5:0]  stall, stall4;
    logic        flush, flush4;
    logic [31:0] new_pc, new_pc4;
    logic        stall_timeout, stall_timeout4;
    logic [31:0] perf_stall_cnt, perf_stall_cnt4;
    logic [15:0] perf_exc_cnt, perf_exc_cnt4;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout),
        .perf_stall_cnt(perf_stall_cnt), .perf_exc_cnt(perf_exc_cnt)
    );

    pipeline_ctrl #(.STALL_TIMEOUT(8'd4)) dut4 (
        .clk(clk), .resetn(resetn),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4),
        .stall_timeout(stall_timeout4),
        .perf_stall_cnt(perf_stall_cnt4), .perf_exc_cnt(perf_exc_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: "did we flush last cycle" plus plain counters.
    bit     m_masked = 1'b0;
    int     m_run    = 0;
    longint m_pstall = 0;
    int     m_pexc   = 0;
    bit     m_to     = 1'b0;
    bit     m_to4    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // q = {mem, ex, id, if}; deepest requesting stage decides how many stages hold.
    task automatic model_out(input logic r, input logic [3:0] q, input logic [31:0] e,
                             input logic [31:0] p, output logic [5:0] s,
                             output logic f, output logic [31:0] pc);
        int n;
        s = '0; f = 1'b0; pc = '0;
        if (r) return;
        if (!m_masked && e != 0) begin
            f  = 1'b1;
            pc = (e == 32'he) ? p : 32'h20;
            return;
        end
        n = q[3] ? 5 : q[2] ? 4 : q[1] ? 3 : q[0] ? 2 : 0;
        s = 6'((1 << n) - 1);
    endtask

    task automatic model_step(input logic r, input logic [5:0] s, input logic f);
        if (r) begin
            m_masked = 0; m_run = 0; m_pstall = 0; m_pexc = 0; m_to = 0; m_to4 = 0;
            return;
        end
        m_masked = f;
        if (s != 0) begin
            if (m_pstall < 64'hFFFF_FFFF) m_pstall++;
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run == 255) m_to = 1;
            if (m_run == 4) m_to4 = 1;
        end else begin
            m_run = 0;
        end
        if (f && m_pexc < 65535) m_pexc++;
    endtask

    task automatic apply(input logic r, input logic [3:0] q, input logic [31:0] e,
                         input logic [31:0] p, output logic [5:0] so,
                         output logic fo, output logic [31:0] po);
        logic [5:0]  es;
        logic        ef;
        logic [31:0] ep;
        resetn = r;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = q;
        excepttype = e;
        cp0_epc = p;
        #1;
        model_out(r, q, e, p, es, ef, ep);
        chk("stall", 64'(stall), 64'(es));
        chk("flush", 64'(flush), 64'(ef));
        chk("new_pc", 64'(new_pc), 64'(ep));
        chk("stall_t4", 64'(stall4), 64'(es));
        chk("flush_t4", 64'(flush4), 64'(ef));
        so = stall; fo = flush; po = new_pc;
        @(posedge clk);
        model_step(r, es, ef);
        #1;
        chk("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_pstall));
        chk("perf_exc_cnt", 64'(perf_exc_cnt), 64'(m_pexc));
        chk("stall_timeout", 64'(stall_timeout), 64'(m_to));
        chk("stall_timeout_t4", 64'(stall_timeout4), 64'(m_to4));
        chk("perf_exc_cnt_t4", 64'(perf_exc_cnt4), 64'(m_pexc));
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  q;
        logic [31:0] e;
        logic [31:0] p;
        logic [5:0]  s;
        logic        f;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [5:0]  so;
        logic        fo;
        logic [31:0] po;
        logic [31:0] codes[7];
        logic        r;
        logic [3:0]  q;
        logic [31:0] e;

        tbl[0]  = '{1'b1, 4'hF, 32'h0,  32'h0,         6'h00, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 4'hF, 32'h0,  32'h0,         6'h1F, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 4'h7, 32'h0,  32'h0,         6'h0F, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 4'h3, 32'h0,  32'h0,         6'h07, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 4'h1, 32'h0,  32'h0,         6'h03, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 4'h0, 32'h0,  32'h0,         6'h00, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 4'h4, 32'h8,  32'h0,         6'h00, 1'b1, 32'h20};
        tbl[7]  = '{1'b0, 4'h4, 32'h8,  32'h0,         6'h0F, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 4'h0, 32'he,  32'hBFC0_0100, 6'h00, 1'b1, 32'hBFC0_0100};
        tbl[9]  = '{1'b0, 4'h0, 32'h0,  32'h0,         6'h00, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 4'h0, 32'ha,  32'h0,         6'h00, 1'b1, 32'h20};
        tbl[11] = '{1'b0, 4'h0, 32'ha,  32'h0,         6'h00, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 4'h0, 32'ha,  32'h0,         6'h00, 1'b1, 32'h20};
        tbl[13] = '{1'b0, 4'h8, 32'h1,  32'h0,         6'h1F, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 4'h8, 32'h1,  32'h0,         6'h00, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 4'h8, 32'h1,  32'h0,         6'h00, 1'b1, 32'h20};

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].r, tbl[i].q, tbl[i].e, tbl[i].p, so, fo, po);
            chk($sformatf("vec%0d_stall", i), 64'(so), 64'(tbl[i].s));
            chk($sformatf("vec%0d_flush", i), 64'(fo), 64'(tbl[i].f));
            chk($sformatf("vec%0d_new_pc", i), 64'(po), 64'(tbl[i].pc));
            if (i == 7)  chk("exc_cnt_after_mask", 64'(perf_exc_cnt), 64'd1);
            if (i == 12) chk("exc_cnt_back_to_back", 64'(perf_exc_cnt), 64'd4);
            if (i == 14) begin
                chk("rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
                chk("rst_exc_cnt", 64'(perf_exc_cnt), 64'd0);
                chk("rst_timeout", 64'(stall_timeout), 64'd0);
            end
        end

        // Short stalls separated by a free cycle must not trip a 4-cycle watchdog.
        apply(1'b1, 4'h0, 32'h0, 32'h0, so, fo, po);
        for (int i = 0; i < 3; i++) apply(1'b0, 4'h8, 32'h0, 32'h0, so, fo, po);
        apply(1'b0, 4'h0, 32'h0, 32'h0, so, fo, po);
        for (int i = 0; i < 3; i++) apply(1'b0, 4'h8, 32'h0, 32'h0, so, fo, po);
        chk("t4_split_stall", 64'(stall_timeout4), 64'd0);
        apply(1'b0, 4'h8, 32'h0, 32'h0, so, fo, po);
        chk("t4_fourth_stall", 64'(stall_timeout4), 64'd1);

        // 255 consecutive stalled cycles set the default watchdog, and it sticks.
        apply(1'b1, 4'h0, 32'h0, 32'h0, so, fo, po);
        for (int i = 0; i < 254; i++) apply(1'b0, 4'h8, 32'h0, 32'h0, so, fo, po);
        chk("wd_254", 64'(stall_timeout), 64'd0);
        apply(1'b0, 4'h8, 32'h0, 32'h0, so, fo, po);
        chk("wd_255", 64'(stall_timeout), 64'd1);
        chk("wd_stall_cnt", 64'(perf_stall_cnt), 64'd255);
        apply(1'b0, 4'h0, 32'h0, 32'h0, so, fo, po);
        chk("wd_sticky", 64'(stall_timeout), 64'd1);

        // Reset during a stall with a pending exception, then normal operation.
        apply(1'b1, 4'hF, 32'hc, 32'h0, so, fo, po);
        chk("rst_mid_flush", 64'(fo), 64'd0);
        chk("rst_mid_timeout", 64'(stall_timeout), 64'd0);
        chk("rst_mid_stall_cnt", 64'(perf_stall_cnt), 64'd0);
        apply(1'b0, 4'h2, 32'h0, 32'h0, so, fo, po);
        chk("post_rst_stall", 64'(so), 64'h07);

        codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h1234_5678};
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(199) == 0);
            q = 4'($urandom) & 4'($urandom);
            e = ($urandom_range(5) == 0) ? codes[$urandom_range(6)] : 32'h0;
            apply(r, q, e, $urandom, so, fo, po);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the six-stage CPU pipeline (PC, IF, ID, EX, MEM, WB). Merges per-stage stall requests into the `stall[5:0]` vector consumed by every pipeline register, including EX_MEM, which honours the stall[3]/stall[4] bubble rule. Sequences exception and ERET redirection through a small FSM that flushes the pipeline and masks re-entry. Keeps stall-performance counters and a stall watchdog.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0020, exception handler entry address
- STALL_TIMEOUT, 8'd255, consecutive stalled cycles before `stall_timeout` sets (8-bit)

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous reset, active-high: 1 resets the block (matches `RstEnable)
- stallreq_if  in  1  instruction-bus wait
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle EX op (div/madd) busy
- stallreq_mem  in  1  data-bus wait
- excepttype  in  32  exception code from MEM stage; 0 = none
- cp0_epc  in  32  current EPC from CP0
- stall  out  6  bit i = stage i holds (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
- flush  out  1  clear all pipeline registers this cycle
- new_pc  out  32  redirect target, valid when flush=1
- stall_timeout  out  1  sticky watchdog flag
- perf_stall_cnt  out  32  total cycles with stall!=0, saturating
- perf_exc_cnt  out  16  flushes taken, saturating

## Operation
- Stall vector (combinational, highest priority first, only in IDLE with no flush):
  - stallreq_mem -> 6'b011111
  - stallreq_ex -> 6'b001111
  - stallreq_id -> 6'b000111
  - stallreq_if -> 6'b000011
  - none -> 6'b000000
- Exception decode (combinational, IDLE only): excepttype != 0 -> flush=1, stall=0.
  - excepttype == 32'h0000_000e (ERET) -> new_pc = cp0_epc.
  - All other nonzero codes (0x1, 0x8, 0xa, 0xc, 0xd, …) -> new_pc = EXC_VECTOR.
- Flush overrides all stall requests in the same cycle.
- FSM states:
  - IDLE: on flush, go to MASK.
  - MASK: one cycle. flush=0, excepttype ignored, stall computed normally. Then go to IDLE. Prevents a stale MEM-stage excepttype of the flushed instruction from re-firing.
- new_pc = 0 whenever flush=0.
- Watchdog: 8-bit `run_cnt` increments each cycle with stall != 0 and clears on any cycle with stall == 0. When run_cnt == STALL_TIMEOUT, stall_timeout sets and stays set until reset. run_cnt saturates at 8'hFF.
- perf_stall_cnt increments on each cycle with stall != 0 and saturates at 32'hFFFF_FFFF. perf_exc_cnt increments on each flush cycle and saturates at 16'hFFFF.

## Timing
- stall, flush and new_pc are combinational from the inputs and current state, so they take effect in the same cycle. All pipeline registers sample them at the next rising clk.
- State, run_cnt, stall_timeout and the perf counters update on the rising clk.
- Reset (resetn=1 at a clk edge) forces the following. Reset wins over any pending flush or stall.
  - state=IDLE, run_cnt=0, stall_timeout=0, perf_stall_cnt=0, perf_exc_cnt=0.
  - During the reset cycle the outputs are driven to stall=0, flush=0, new_pc=0.
- An exception arriving in the same cycle as any stallreq gives flush=1, stall=0. The stall is not counted.
- Back-to-back exceptions: an exception in the MASK cycle is dropped. An exception in the following cycle is taken.
- Flush latency is 0 cycles from excepttype becoming valid. The minimum spacing between two flushes is 2 cycles.

## Test plan
- Priority: assert stallreq_if, stallreq_id, stallreq_ex and stallreq_mem together -> stall=6'b011111. Drop stallreq_mem -> 6'b001111. Drop stallreq_ex -> 6'b000111. Drop stallreq_id -> 6'b000011.
- Exception: excepttype=32'h8 with stallreq_ex=1 -> the same cycle gives flush=1, new_pc=32'h20, stall=0. Hold excepttype for one more cycle -> flush=0 (MASK), and perf_exc_cnt=1.
- ERET: cp0_epc=32'hBFC0_0100, excepttype=32'he -> flush=1, new_pc=32'hBFC0_0100.
- Back-to-back exceptions: pulse excepttype=0xa for 3 consecutive cycles -> flush pattern 1,0,1, and perf_exc_cnt=2.
- Watchdog: hold stallreq_mem for 255 cycles -> stall_timeout rises at the edge where run_cnt reaches 255 and stays set after the stall ends. With STALL_TIMEOUT=4, a 3-cycle stall, 1 idle cycle and another 3-cycle stall -> stall_timeout stays 0.
- Reset mid-operation: assert resetn during a stall and a pending exception -> next cycle state=IDLE, all counters 0, stall_timeout=0, and outputs follow the inputs again after resetn drops.
